button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_pkg.sv | 13 +
 rtl/button_debounce_ch.sv | 101 ++++++++++
 rtl/button_debounce.sv | 37 +++
 tb/tb_button_debounce.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and stable-state encoding for the button debouncer.
package button_pkg;

    // 10 ms and 1 s at a 25 MHz button clock
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_LONG_CYCLES     = 25000000;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_e;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce qualifier, hold timer,
// press/release/long pulses and a press-driven toggle.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic btn_clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_toggle
);

    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam int   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int   HW       = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic            sync_q1, sync_q2, sync;
    btn_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q;
    logic            press_d, release_d, toggle_d;

    // Two-flop synchronizer, parked at the idle raw level in reset
    always_ff @(posedge btn_clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= IDLE_RAW;
            sync_q2 <= IDLE_RAW;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    assign sync = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    // Debounce state register plus the registered event outputs
    always_ff @(posedge btn_clk or posedge rst) begin
        if (rst) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_toggle  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_toggle  <= toggle_d;
        end
    end

    // Qualify a change only after DEBOUNCE_CYCLES consecutive differing samples;
    // any return to the stable level restarts the count
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = btn_toggle;
        if (btn_state_e'(sync) != state_q) begin
            if (cnt_q == DB_LAST) begin
                state_d   = btn_state_e'(sync);
                press_d   = sync;
                release_d = ~sync;
                toggle_d  = btn_toggle ^ sync;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign btn_level = (state_q == PRESSED);

    // Hold timer saturates at LONG_CYCLES so the long pulse fires once per press
    always_ff @(posedge btn_clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            btn_long <= 1'b0;
        end else if (btn_level) begin
            if (hold_q != HOLD_MAX)
                hold_q <= hold_q + HW'(1);
            btn_long <= (hold_q == HOLD_LAST);
        end else begin
            hold_q   <= '0;
            btn_long <= 1'b0;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// N independent debounced button channels.
module button_debounce
    import button_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic         btn_clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_long,
    output logic [N-1:0] btn_toggle
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .btn_clk     (btn_clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i]),
            .btn_toggle  (btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bouncing checked
// against a run-length reference model.
module tb_button_debounce;

    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 16;

    logic         btn_clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_toggle;

    int n_pass  = 0;
    int n_total = 0;

    button_debounce #(.N(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut (
        .btn_clk     (btn_clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_toggle  (btn_toggle)
    );

    always #5 btn_clk = ~btn_clk;

    // Reference model: "pressed" history two samples deep, length of the run of
    // samples disagreeing with the accepted level, and cycles since the press.
    logic [1:0]   m_hist [N];
    int           m_run  [N];
    int           m_age  [N];
    logic [N-1:0] m_level, m_press, m_rel, m_long, m_tog;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_hist[c] = 2'b00;
            m_run[c]  = 0;
            m_age[c]  = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_tog = '0;
    endtask

    task automatic model_edge();
        logic seen, was;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            seen      = m_hist[c][1];
            m_hist[c] = {m_hist[c][0], ~btn_in[c]};
            was       = m_level[c];
            m_age[c]  = was ? m_age[c] + 1 : 0;
            m_long[c] = was && (m_age[c] == L);
            m_run[c]  = (seen != was) ? m_run[c] + 1 : 0;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (m_run[c] == D) begin
                m_run[c]   = 0;
                m_level[c] = seen;
                m_press[c] = seen;
                m_rel[c]   = ~seen;
                if (seen) m_tog[c] = ~m_tog[c];
            end
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge
    task automatic step();
        @(posedge btn_clk);
        model_edge();
        @(negedge btn_clk);
    endtask

    task automatic settle(input int n);
        btn_in = '1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = '1;
        model_reset();
        step(); step();
        n_total++;
        if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !== 20'h0)
            $display("FAIL reset_outputs got %h want 0",
                     {btn_level, btn_press, btn_release, btn_long, btn_toggle});
        else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !== 20'h0)
                $display("FAIL reset_idle k=%0d got %h want 0", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle});
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        settle(12);
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL clean_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
            if (k == 5) begin
                n_total++;
                if (btn_level[0] !== 1'b0) $display("FAIL clean_early level=%b want 0", btn_level[0]);
                else n_pass++;
            end
            if (k == 6) begin
                n_total++;
                if ({btn_level[0], btn_press[0], btn_toggle[0]} !== 3'b111)
                    $display("FAIL clean_accept lvl/press/tog=%b want 111",
                             {btn_level[0], btn_press[0], btn_toggle[0]});
                else n_pass++;
            end
            if (k == 7) begin
                n_total++;
                if (btn_press[0] !== 1'b0) $display("FAIL clean_pulse_width press=%b want 0", btn_press[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        settle(12);
        btn_in[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); presses += btn_press[1]; end
        btn_in[1] = 1'b1;
        step(); presses += btn_press[1];
        btn_in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            presses += btn_press[1];
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL bounce_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
            if (k == 5) begin
                n_total++;
                if (btn_level[1] !== 1'b0) $display("FAIL bounce_early level=%b want 0", btn_level[1]);
                else n_pass++;
            end
            if (k == 6) begin
                n_total++;
                if (btn_press[1] !== 1'b1) $display("FAIL bounce_accept press=%b want 1", btn_press[1]);
                else n_pass++;
            end
        end
        n_total++;
        if (presses != 1) $display("FAIL bounce_count presses=%0d want 1", presses);
        else n_pass++;
    endtask

    task automatic test_long_press();
        int longs = 0;
        settle(12);
        btn_in[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            longs += btn_long[2];
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL long_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
            if (k == 22) begin
                n_total++;
                if (btn_long[2] !== 1'b1) $display("FAIL long_pulse long=%b want 1", btn_long[2]);
                else n_pass++;
            end
            if (k == 36) begin
                n_total++;
                if (btn_release[2] !== 1'b1) $display("FAIL long_release rel=%b want 1", btn_release[2]);
                else n_pass++;
            end
            if (k == 30) btn_in[2] = 1'b1;
        end
        n_total++;
        if (longs != 1) $display("FAIL long_count pulses=%0d want 1", longs);
        else n_pass++;
    endtask

    task automatic test_short_press();
        int longs = 0;
        settle(12);
        btn_in[3] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            longs += btn_long[3];
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL short_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
            if (k == 6) begin
                n_total++;
                if ({btn_press[3], btn_toggle[3]} !== 2'b11)
                    $display("FAIL short_press press/tog=%b want 11", {btn_press[3], btn_toggle[3]});
                else n_pass++;
            end
            if (k == 16) begin
                n_total++;
                if (btn_release[3] !== 1'b1) $display("FAIL short_release rel=%b want 1", btn_release[3]);
                else n_pass++;
            end
            if (k == 10) btn_in[3] = 1'b1;
        end
        n_total++;
        if (longs != 0) $display("FAIL short_no_long pulses=%0d want 0", longs);
        else n_pass++;
        settle(12);
        btn_in[3] = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        n_total++;
        if ({btn_press[3], btn_toggle[3]} !== 2'b10)
            $display("FAIL short_second_toggle press/tog=%b want 10", {btn_press[3], btn_toggle[3]});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        settle(12);
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !== 20'h0)
            $display("FAIL rstmid_async got %h want 0",
                     {btn_level, btn_press, btn_release, btn_long, btn_toggle});
        else n_pass++;
        step(); step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL rstmid_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
            n_total++;
            if (btn_press !== ((k == 6) ? 4'b0001 : 4'b0000))
                $display("FAIL rstmid_press k=%0d press=%b", k, btn_press);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        settle(12);
        btn_in = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_total++;
            if (btn_press !== ((k == 6) ? 4'b1111 : 4'b0000))
                $display("FAIL simul_press k=%0d press=%b", k, btn_press);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int remain [N];
        for (int c = 0; c < N; c++) remain[c] = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                remain[c]--;
                if (remain[c] <= 0) begin
                    btn_in[c] = ~btn_in[c];
                    remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 40))
                                                            : int'($urandom_range(1, 6));
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            step();
            n_total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_toggle} !==
                {m_level, m_press, m_rel, m_long, m_tog})
                $display("FAIL random_model k=%0d got %h want %h", k,
                         {btn_level, btn_press, btn_release, btn_long, btn_toggle},
                         {m_level, m_press, m_rel, m_long, m_tog});
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_short_press();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
